// File: rtl/amba_axi4_stream_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : amba_axi4_stream_fifo_if
// Purpose  : AXI4-Stream channel bundle with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface amba_axi4_stream_fifo_if #(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ID_PORT_WIDTH    = 8,
    parameter int DEST_PORT_WIDTH  = 4,
    parameter int USER_PORT_WIDTH  = 1
);
    logic                          tvalid;
    logic                          tready;
    logic [8*DATA_WIDTH_BYTES-1:0] tdata;
    logic [DATA_WIDTH_BYTES-1:0]   tstrb;
    logic [DATA_WIDTH_BYTES-1:0]   tkeep;
    logic                          tlast;
    logic [ID_PORT_WIDTH-1:0]      tid;
    logic [DEST_PORT_WIDTH-1:0]    tdest;
    logic [USER_PORT_WIDTH-1:0]    tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/amba_axi4_stream_fifo.sv
`default_nettype none
// ============================================================================
// Module   : amba_axi4_stream_fifo
// Purpose  : First-word-fall-through AXI4-Stream FIFO, optional packet mode.
// Revision : 1.0 - initial release
// ============================================================================
module amba_axi4_stream_fifo #(
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int ID_WIDTH         = 8,
    parameter int DEST_WIDTH       = 4,
    parameter int USER_WIDTH       = 0,
    parameter int DEPTH            = 16,
    parameter int PACKET_MODE      = 0,
    localparam int CW              = $clog2(DEPTH) + 1
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    amba_axi4_stream_fifo_if.slave  s_axis,
    amba_axi4_stream_fifo_if.master m_axis,
    output logic [CW-1:0]           occupancy,
    output logic [CW-1:0]           pkt_count
);
    localparam int PW  = $clog2(DEPTH);
    localparam int DW  = 8 * DATA_WIDTH_BYTES;
    localparam int IDW = (ID_WIDTH   == 0) ? 1 : ID_WIDTH;
    localparam int DSW = (DEST_WIDTH == 0) ? 1 : DEST_WIDTH;
    localparam int USW = (USER_WIDTH == 0) ? 1 : USER_WIDTH;
    localparam int EW  = DW + 2 * DATA_WIDTH_BYTES + 1 + IDW + DSW + USW;

    logic [EW-1:0]  mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  occ_q, occ_d;
    logic [CW-1:0]  pkt_q, pkt_d;
    logic           ready_q;
    logic           force_release_q, force_release_d;

    logic           push, pop, full, empty, m_valid;
    logic [EW-1:0]  wr_entry, rd_entry;
    logic [IDW-1:0] rd_id;
    logic [DSW-1:0] rd_dest;
    logic [USW-1:0] rd_user;

    assign full  = (occ_q == CW'(DEPTH));
    assign empty = (occ_q == '0);

    // In packet mode a beat is only visible once a whole packet is stored,
    // unless the FIFO filled up without one (oversize packet drains anyway).
    assign m_valid = !ARESET && !empty &&
                     ((PACKET_MODE == 0) || (pkt_q != '0) || force_release_q);

    assign s_axis.tready = ready_q && !ARESET;
    assign m_axis.tvalid = m_valid;

    assign push = s_axis.tvalid && s_axis.tready;
    assign pop  = m_valid && m_axis.tready;

    assign wr_entry = {s_axis.tdata, s_axis.tstrb, s_axis.tkeep, s_axis.tlast,
                       s_axis.tid, s_axis.tdest, s_axis.tuser};
    assign rd_entry = mem_q[rd_ptr_q];
    assign {m_axis.tdata, m_axis.tstrb, m_axis.tkeep, m_axis.tlast,
            rd_id, rd_dest, rd_user} = rd_entry;

    assign m_axis.tid   = (ID_WIDTH   == 0) ? '0 : rd_id;
    assign m_axis.tdest = (DEST_WIDTH == 0) ? '0 : rd_dest;
    assign m_axis.tuser = (USER_WIDTH == 0) ? '0 : rd_user;

    assign occupancy = occ_q;
    assign pkt_count = pkt_q;

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q;
        force_release_d = force_release_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
        endcase

        pkt_d = pkt_q + CW'(push && s_axis.tlast) - CW'(pop && m_axis.tlast);

        if (PACKET_MODE != 0) begin
            if (pop && m_axis.tlast)
                force_release_d = 1'b0;
            else if (full && (pkt_q == '0))
                force_release_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            occ_q           <= '0;
            pkt_q           <= '0;
            force_release_q <= 1'b0;
            ready_q         <= 1'b1;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
            pkt_q           <= pkt_d;
            force_release_q <= force_release_d;
            ready_q         <= (occ_d != CW'(DEPTH));
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end
endmodule
`default_nettype wire
